// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword layout helpers and health states.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        H_OK       = 2'd0,
        H_DEGRADED = 2'd1,
        H_ALARM    = 2'd2
    } health_e;

    // Bit i of the codeword is Hamming position i+1.
    function automatic logic [CODE_W-1:0] ham_encode(input logic [DATA_W-1:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0],
                d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [2:0] ham_syndrome(input logic [CODE_W-1:0] cw);
        return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    endfunction

endpackage

// File: rtl/hamming_corrector.sv
// Combinational single-error corrector; double errors miscorrect silently.
module hamming_corrector
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [DATA_W-1:0] data_o,
    output logic [2:0]        syndrome_o,
    output logic              corrected_o
);

    logic [CODE_W-1:0] fixed;

    assign syndrome_o  = ham_syndrome(code_i);
    assign corrected_o = (syndrome_o != 3'd0);

    // A nonzero syndrome names the 1-based position of the flipped bit.
    always_comb begin
        fixed = code_i;
        if (syndrome_o != 3'd0)
            fixed[syndrome_o - 3'd1] = ~fixed[syndrome_o - 3'd1];
    end

    assign data_o = {fixed[6], fixed[5], fixed[4], fixed[2]};

endmodule

// File: rtl/hamming_decode_monitor.sv
// Post-voter decode stage: one-word output buffer, corrected-word counter and health FSM.
module hamming_decode_monitor
    import hamming_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int ALARM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    input  logic             in_vote_fault,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_corrected,
    output logic [CNT_W-1:0] corr_count,
    output logic [1:0]       health,
    output logic             alarm,
    input  logic             clear
);

    logic [DATA_W-1:0] dec_data;
    logic [2:0]        dec_syn;
    logic              dec_corr;
    logic              accept;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_corr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cons_q, cons_d;
    health_e           health_q, health_d;

    hamming_corrector u_corr (
        .code_i      (in_code),
        .data_o      (dec_data),
        .syndrome_o  (dec_syn),
        .corrected_o (dec_corr)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_corr_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= dec_data;
            out_corr_q  <= dec_corr;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // clear dominates a coinciding accept for all bookkeeping state.
    always_comb begin
        cnt_d    = cnt_q;
        cons_d   = cons_q;
        health_d = health_q;
        if (clear) begin
            cnt_d    = '0;
            cons_d   = '0;
            health_d = H_OK;
        end else if (accept) begin
            if (dec_corr) begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                if (cons_q != 4'hF)         cons_d = cons_q + 4'd1;
            end else begin
                cons_d = '0;
            end
            case (health_q)
                H_OK:
                    if (dec_corr || in_vote_fault) health_d = H_DEGRADED;
                H_DEGRADED:
                    if (cons_d >= 4'(ALARM_THRESH))        health_d = H_ALARM;
                    else if (!dec_corr && !in_vote_fault) health_d = H_OK;
                H_ALARM:
                    health_d = H_ALARM;
                default:
                    health_d = H_OK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cons_q   <= '0;
            health_q <= H_OK;
        end else begin
            cnt_q    <= cnt_d;
            cons_q   <= cons_d;
            health_q <= health_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_corrected = out_corr_q;
    assign corr_count    = cnt_q;
    assign health        = health_q;
    assign alarm         = (health_q == H_ALARM);

endmodule

// File: tb/tb_hamming_decode_monitor.sv
// Randomized scoreboard bench for hamming_decode_monitor with directed corner cases.
module tb_hamming_decode_monitor;

    localparam int TB_CNT_W = 2;
    localparam int THRESH   = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [6:0]          in_code;
    logic                in_vote_fault;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_data;
    logic                out_corrected;
    logic [TB_CNT_W-1:0] corr_count;
    logic [1:0]          health;
    logic                alarm;
    logic                clear;

    hamming_decode_monitor #(.CNT_W(TB_CNT_W), .ALARM_THRESH(THRESH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .in_vote_fault (in_vote_fault),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_corrected (out_corrected),
        .corr_count    (corr_count),
        .health        (health),
        .alarm         (alarm),
        .clear         (clear)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected response of the word currently on the input: what was encoded and whether a bit was flipped.
    logic [3:0] cur_exp_data;
    logic       cur_err;
    logic [4:0] sbq[$];

    int m_cnt = 0, m_cons = 0, m_h = 0;

    logic rdy_mode = 1'b0;
    logic ready_fix = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    always begin
        @(posedge clk);
        #2;
        out_ready = rdy_mode ? ($urandom % 4 != 0) : ready_fix;
    end

    // Reference model: observes accepts, queues the expected word, advances health bookkeeping.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            m_cnt = 0; m_cons = 0; m_h = 0;
            sbq.delete();
        end else begin
            logic acc;
            acc = in_valid && in_ready;
            if (acc) sbq.push_back({cur_err, cur_exp_data});
            if (clear) begin
                m_cnt = 0; m_cons = 0; m_h = 0;
            end else if (acc) begin
                if (cur_err) begin
                    m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                    m_cons = (m_cons < 15) ? m_cons + 1 : 15;
                end else begin
                    m_cons = 0;
                end
                if (m_h == 0) begin
                    if (cur_err || in_vote_fault) m_h = 1;
                end else if (m_h == 1) begin
                    if (m_cons >= THRESH) m_h = 2;
                    else if (!cur_err && !in_vote_fault) m_h = 0;
                end
            end
        end
    end

    // Monitor: pops on every delivered word and tracks status outputs.
    always begin
        @(negedge clk);
        if (rst_n) begin
            chk("corr_count", corr_count, m_cnt);
            chk("health", health, m_h);
            chk("alarm", alarm, (m_h == 2) ? 1 : 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    logic [4:0] e;
                    e = sbq.pop_front();
                    chk("out_data", out_data, e[3:0]);
                    chk("out_corrected", out_corrected, e[4]);
                end
            end
        end
    end

    task automatic send(input logic [6:0] code, input logic [3:0] d, input logic err, input logic vf);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1; in_code = code; in_vote_fault = vf;
        cur_exp_data = d; cur_err = err;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_within_bound", acc, 1);
        in_valid = 1'b0;
        in_vote_fault = 1'b0;
    endtask

    task automatic send_err(input logic [3:0] d);
        logic [6:0] c;
        int pos;
        c = encode(d);
        pos = $urandom_range(0, 6);
        c[pos] = ~c[pos];
        send(c, d, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_vote_fault = 1'b0;
        clear = 1'b0; out_ready = 1'b0; cur_exp_data = '0; cur_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_corrected", out_corrected, 0);
        chk("rst_corr_count", corr_count, 0);
        chk("rst_health", health, 0);
        chk("rst_alarm", alarm, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(7'b1010010, 4'b1010, 1'b0, 1'b0);
        @(negedge clk);
        chk("clean_data", out_data, 4'b1010);
        chk("clean_corrected", out_corrected, 0);
        @(posedge clk); #1;
        send(7'b1000010, 4'b1010, 1'b1, 1'b0);
        @(negedge clk);
        chk("sbe_data", out_data, 4'b1010);
        chk("sbe_corrected", out_corrected, 1);
        chk("sbe_count", corr_count, 1);
        chk("sbe_health", health, 1);
        @(posedge clk); #1;
        send(7'b1010010, 4'b1010, 1'b0, 1'b0);
        @(negedge clk);
        chk("recover_health", health, 0);
        @(posedge clk); #1;

        ready_fix = 1'b0;
        @(posedge clk); #1;
        send(encode(4'h5), 4'h5, 1'b0, 1'b0);
        in_valid = 1'b1; in_code = encode(4'hC); cur_exp_data = 4'hC; cur_err = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 4'h5);
        end
        @(posedge clk); #1;
        ready_fix = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        repeat (4) send(7'b0000001, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("alarm_health", health, 2);
        chk("alarm_flag", alarm, 1);
        @(posedge clk); #1;
        send(encode(4'h9), 4'h9, 1'b0, 1'b0);
        @(negedge clk);
        chk("alarm_sticky", health, 2);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_health", health, 0);
        chk("clear_count", corr_count, 0);
        @(posedge clk); #1;

        repeat (5) send_err(4'($urandom));
        @(negedge clk);
        chk("sat_count", corr_count, CNT_MAX);
        @(posedge clk); #1;

        ready_fix = 1'b0;
        @(posedge clk); #1;
        send_err(4'h3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", corr_count, 0);
        chk("arst_health", health, 0);
        chk("arst_alarm", alarm, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_fix = 1'b1;
        @(posedge clk); #1;

        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] d;
            logic [6:0] c;
            logic       e;
            int         pos;
            if ($urandom % 5 == 0) begin
                @(posedge clk); #1;
            end
            d = 4'($urandom);
            c = encode(d);
            e = ($urandom % 3 == 0);
            if (e) begin
                pos = $urandom_range(0, 6);
                c[pos] = ~c[pos];
            end
            clear = ($urandom % 25 == 0);
            send(c, d, e, ($urandom % 8 == 0));
            clear = 1'b0;
        end
        rdy_mode = 1'b0;
        ready_fix = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
